// File: rtl/serial_frame_receiver_if.sv
// ---------------------------------------------------------------------------
// serial_frame_receiver_if
//   Groups the serial input stream and the valid/ready word output of the
//   serial frame receiver.
//   Signals:
//     ser_in     serial bit, line idles high
//     ser_valid  ser_in carries a valid bit this cycle
//     out_ready  consumer accepts out_data this cycle
//     out_data   assembled word, LSB = first data bit received
//     out_valid  out_data holds an unconsumed word
//     frame_err  one-cycle pulse, stop bit sampled as 0
//     overrun    one-cycle pulse, completed word dropped (hold register full)
//   Modports:
//     master  environment side: drives the serial stream and out_ready
//     slave   receiver side: consumes the stream, drives the word port
// ---------------------------------------------------------------------------
interface serial_frame_receiver_if #(
    parameter int DATA_W = 8
);
    logic              ser_in;
    logic              ser_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              frame_err;
    logic              overrun;

    modport master (
        output ser_in,
        output ser_valid,
        output out_ready,
        input  out_data,
        input  out_valid,
        input  frame_err,
        input  overrun
    );

    modport slave (
        input  ser_in,
        input  ser_valid,
        input  out_ready,
        output out_data,
        output out_valid,
        output frame_err,
        output overrun
    );
endinterface

// File: rtl/serial_frame_receiver.sv
// ---------------------------------------------------------------------------
// serial_frame_receiver
//   Samples a start/data/stop framed serial stream (one bit per cycle while
//   ser_valid is high), assembles DATA_W-bit words LSB first and presents
//   them through a one-entry valid/ready hold register. Bad stop bits raise
//   frame_err; good words arriving while the hold register is occupied and
//   not being drained are dropped and raise overrun.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    serial_frame_receiver_if.slave (serial in, word out, pulses)
// ---------------------------------------------------------------------------
module serial_frame_receiver #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_frame_receiver_if.slave bus
);
    localparam int                CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [CNT_W-1:0]    bit_cnt_q,   bit_cnt_d;
    logic [DATA_W-1:0]   shift_q,     shift_d;
    logic [DATA_W-1:0]   out_data_q,  out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                overrun_q,   overrun_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        out_data_d  = out_data_q;
        // A pending word is consumed on any edge where the consumer is ready;
        // a load below may set it again on the same edge.
        out_valid_d = out_valid_q & ~bus.out_ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (bus.ser_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.ser_in) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    // Shift right from the MSB so the first data bit lands at bit 0.
                    shift_d = {bus.ser_in, shift_q[DATA_W-1:1]};
                    if (bit_cnt_q == LAST) begin
                        state_d   = STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    // A 0 here is an error, never a new start bit.
                    state_d = IDLE;
                    if (bus.ser_in) begin
                        if (!out_valid_q || bus.out_ready) begin
                            out_data_d  = shift_q;
                            out_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_serial_frame_receiver.sv
module tb_serial_frame_receiver;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    serial_frame_receiver_if #(.DATA_W(8)) bus ();

    serial_frame_receiver #(.DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame: start 0, data LSB first, stop bit. 'gaps' idle
    // (ser_valid=0) cycles with random ser_in are inserted between bits.
    // out_ready takes rdy_stop on the stop-bit edge. Returns at the falling
    // edge right after the stop-bit sample.
    task automatic send_frame(input logic [7:0] w, input logic stop_b,
                              input int gaps, input logic rdy_stop);
        logic [9:0] bits;
        bits = {stop_b, w, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gaps; g++) begin
                    bus.ser_valid = 1'b0;
                    bus.ser_in    = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
            end
            if (i == 9) bus.out_ready = rdy_stop;
            bus.ser_valid = 1'b1;
            bus.ser_in    = bits[i];
            @(negedge clk);
        end
        bus.ser_valid = 1'b0;
        bus.ser_in    = 1'b1;
    endtask

    task automatic expect_word(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) chk({tag, "_data"}, 32'(bus.out_data), 32'(sb[0]));
    endtask

    initial begin
        reset         = 1'b1;
        bus.ser_in    = 1'b1;
        bus.ser_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data",  32'(bus.out_data),  32'd0);
        chk("rst_ferr",  32'(bus.frame_err), 32'd0);
        chk("rst_ovr",   32'(bus.overrun),   32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1. Basic frame, out_valid high for exactly one cycle
        bus.out_ready = 1'b1;
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 0, 1'b1);
        expect_word("t1");
        void'(sb.pop_front());
        @(negedge clk);
        chk("t1_valid_drop", 32'(bus.out_valid), 32'd0);

        // 2. Stalls between every bit
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 2, 1'b1);
        expect_word("t2");
        void'(sb.pop_front());
        chk("t2_ferr", 32'(bus.frame_err), 32'd0);
        @(negedge clk);
        chk("t2_valid_drop", 32'(bus.out_valid), 32'd0);

        // 3. Frame error, then a good frame
        send_frame(8'h3C, 1'b0, 0, 1'b1);
        chk("t3_ferr",  32'(bus.frame_err), 32'd1);
        chk("t3_valid", 32'(bus.out_valid), 32'd0);
        chk("t3_ovr",   32'(bus.overrun),   32'd0);
        @(negedge clk);
        chk("t3_ferr_pulse", 32'(bus.frame_err), 32'd0);
        sb.push_back(8'h81);
        send_frame(8'h81, 1'b1, 0, 1'b1);
        expect_word("t3b");
        void'(sb.pop_front());
        @(negedge clk);

        // 4. Overrun
        bus.out_ready = 1'b0;
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1, 0, 1'b0);
        expect_word("t4a");
        @(negedge clk);
        send_frame(8'h22, 1'b1, 0, 1'b0);
        chk("t4_ovr",  32'(bus.overrun),   32'd1);
        chk("t4_ferr", 32'(bus.frame_err), 32'd0);
        expect_word("t4b");
        @(negedge clk);
        chk("t4_ovr_pulse", 32'(bus.overrun), 32'd0);
        expect_word("t4c");
        bus.out_ready = 1'b1;
        @(negedge clk);
        void'(sb.pop_front());
        chk("t4_consumed", 32'(bus.out_valid), 32'd0);

        // 5. Consume and load on the same edge
        bus.out_ready = 1'b0;
        sb.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 0, 1'b0);
        expect_word("t5a");
        sb.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 0, 1'b1);
        void'(sb.pop_front());
        chk("t5_ovr", 32'(bus.overrun), 32'd0);
        expect_word("t5b");
        void'(sb.pop_front());
        @(negedge clk);
        chk("t5_valid_drop", 32'(bus.out_valid), 32'd0);

        // 6. Reset mid-frame with a pending word
        bus.out_ready = 1'b0;
        sb.push_back(8'h77);
        send_frame(8'h77, 1'b1, 0, 1'b0);
        expect_word("t6a");
        bus.ser_valid = 1'b1;
        bus.ser_in = 1'b0; @(negedge clk);
        bus.ser_in = 1'b1; @(negedge clk);
        bus.ser_in = 1'b0; @(negedge clk);
        bus.ser_in = 1'b1; @(negedge clk);
        bus.ser_in = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.ser_valid = 1'b0;
        sb.delete();
        chk("t6_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_data",  32'(bus.out_data),  32'd0);
        chk("t6_ferr",  32'(bus.frame_err), 32'd0);
        bus.out_ready = 1'b1;
        sb.push_back(8'hF0);
        send_frame(8'hF0, 1'b1, 0, 1'b1);
        expect_word("t6b");
        void'(sb.pop_front());
        @(negedge clk);
        chk("t6_valid_drop", 32'(bus.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
